// File: rtl/friscv_h.sv
// Shared definitions for the FRISCV APB arbiter.
// Holds the arbiter FSM state type and its encoding.
package friscv_h;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } arb_state_t;

endpackage

// File: rtl/friscv_apb_arbiter.sv
// Two-requester round-robin arbiter in front of one APB-like peripheral.
// One grant at a time, registered outputs, optional ready timeout.
module friscv_apb_arbiter
    import friscv_h::*;
#(
    parameter int ADDRW   = 16,
    parameter int XLEN    = 32,
    parameter int TIMEOUT = 255
)(
    input  logic              aclk,
    input  logic              aresetn,
    input  logic              srst,
    input  logic              s0_en,
    input  logic              s0_wr,
    input  logic [ADDRW-1:0]  s0_addr,
    input  logic [XLEN-1:0]   s0_wdata,
    input  logic [XLEN/8-1:0] s0_strb,
    output logic [XLEN-1:0]   s0_rdata,
    output logic              s0_ready,
    output logic              s0_err,
    input  logic              s1_en,
    input  logic              s1_wr,
    input  logic [ADDRW-1:0]  s1_addr,
    input  logic [XLEN-1:0]   s1_wdata,
    input  logic [XLEN/8-1:0] s1_strb,
    output logic [XLEN-1:0]   s1_rdata,
    output logic              s1_ready,
    output logic              s1_err,
    output logic              slv_en,
    output logic              slv_wr,
    output logic [ADDRW-1:0]  slv_addr,
    output logic [XLEN-1:0]   slv_wdata,
    output logic [XLEN/8-1:0] slv_strb,
    input  logic [XLEN-1:0]   slv_rdata,
    input  logic              slv_ready
);

    localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

    arb_state_t state;
    logic       last;
    logic       gnt;
    logic       win;
    logic       tmo;
    logic       done;
    logic [XLEN-1:0] resp_data;

    // On a tie the requester not granted last wins
    always_comb begin
        win = s1_en;
        if (s0_en && s1_en) begin
            win = ~last;
        end
    end

    assign done      = slv_ready || tmo;
    assign resp_data = slv_ready ? slv_rdata : '0;

    generate
        if (TIMEOUT > 0) begin : gen_tmo
            logic [CW-1:0] cnt;

            always_ff @(posedge aclk or negedge aresetn) begin
                if (!aresetn) begin
                    cnt <= '0;
                end else if (srst || state != ACCESS) begin
                    cnt <= '0;
                end else if (!slv_ready && cnt != CW'(TIMEOUT)) begin
                    cnt <= cnt + CW'(1);
                end
            end

            assign tmo = (state == ACCESS) && (cnt == CW'(TIMEOUT - 1));
        end else begin : gen_no_tmo
            assign tmo = 1'b0;
        end
    endgenerate

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state     <= IDLE;
            last      <= 1'b1;
            gnt       <= 1'b0;
            slv_en    <= 1'b0;
            slv_wr    <= 1'b0;
            slv_addr  <= '0;
            slv_wdata <= '0;
            slv_strb  <= '0;
            s0_ready  <= 1'b0;
            s0_rdata  <= '0;
            s0_err    <= 1'b0;
            s1_ready  <= 1'b0;
            s1_rdata  <= '0;
            s1_err    <= 1'b0;
        end else if (srst) begin
            state     <= IDLE;
            last      <= 1'b1;
            gnt       <= 1'b0;
            slv_en    <= 1'b0;
            slv_wr    <= 1'b0;
            slv_addr  <= '0;
            slv_wdata <= '0;
            slv_strb  <= '0;
            s0_ready  <= 1'b0;
            s0_rdata  <= '0;
            s0_err    <= 1'b0;
            s1_ready  <= 1'b0;
            s1_rdata  <= '0;
            s1_err    <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (s0_en || s1_en) begin
                        gnt       <= win;
                        last      <= win;
                        slv_en    <= 1'b1;
                        slv_wr    <= win ? s1_wr    : s0_wr;
                        slv_addr  <= win ? s1_addr  : s0_addr;
                        slv_wdata <= win ? s1_wdata : s0_wdata;
                        slv_strb  <= win ? s1_strb  : s0_strb;
                        state     <= ACCESS;
                    end
                end
                ACCESS: begin
                    // A ready in the timeout cycle still completes normally
                    if (done) begin
                        slv_en <= 1'b0;
                        state  <= RESP;
                        if (gnt) begin
                            s1_ready <= 1'b1;
                            s1_rdata <= resp_data;
                            s1_err   <= ~slv_ready;
                        end else begin
                            s0_ready <= 1'b1;
                            s0_rdata <= resp_data;
                            s0_err   <= ~slv_ready;
                        end
                    end
                end
                RESP: begin
                    s0_ready <= 1'b0;
                    s0_rdata <= '0;
                    s0_err   <= 1'b0;
                    s1_ready <= 1'b0;
                    s1_rdata <= '0;
                    s1_err   <= 1'b0;
                    state    <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_friscv_apb_arbiter.sv
// Bench for friscv_apb_arbiter: directed and random transactions
// checked against a transaction-level round-robin/latency model.
module tb_friscv_apb_arbiter;

    localparam int ADDRW = 16;
    localparam int XLEN  = 32;
    localparam int TO    = 4;

    logic              aclk = 1'b0;
    logic              aresetn;
    logic              srst;
    logic              s0_en, s1_en;
    logic              s0_wr, s1_wr;
    logic [ADDRW-1:0]  s0_addr, s1_addr;
    logic [XLEN-1:0]   s0_wdata, s1_wdata;
    logic [XLEN/8-1:0] s0_strb, s1_strb;
    logic [XLEN-1:0]   s0_rdata, s1_rdata;
    logic              s0_ready, s1_ready;
    logic              s0_err, s1_err;
    logic              slv_en, slv_wr;
    logic [ADDRW-1:0]  slv_addr;
    logic [XLEN-1:0]   slv_wdata;
    logic [XLEN/8-1:0] slv_strb;
    logic [XLEN-1:0]   slv_rdata;
    logic              slv_ready;

    logic              en_q   [2];
    logic              wr_q   [2];
    logic [ADDRW-1:0]  addr_q [2];
    logic [XLEN-1:0]   wdata_q[2];
    logic [XLEN/8-1:0] strb_q [2];

    int  vectors = 0;
    int  errs    = 0;
    bit  last;

    assign s0_en    = en_q[0];
    assign s1_en    = en_q[1];
    assign s0_wr    = wr_q[0];
    assign s1_wr    = wr_q[1];
    assign s0_addr  = addr_q[0];
    assign s1_addr  = addr_q[1];
    assign s0_wdata = wdata_q[0];
    assign s1_wdata = wdata_q[1];
    assign s0_strb  = strb_q[0];
    assign s1_strb  = strb_q[1];

    always #5 aclk = ~aclk;

    friscv_apb_arbiter #(
        .ADDRW   (ADDRW),
        .XLEN    (XLEN),
        .TIMEOUT (TO)
    ) dut (
        .aclk      (aclk),
        .aresetn   (aresetn),
        .srst      (srst),
        .s0_en     (s0_en),
        .s0_wr     (s0_wr),
        .s0_addr   (s0_addr),
        .s0_wdata  (s0_wdata),
        .s0_strb   (s0_strb),
        .s0_rdata  (s0_rdata),
        .s0_ready  (s0_ready),
        .s0_err    (s0_err),
        .s1_en     (s1_en),
        .s1_wr     (s1_wr),
        .s1_addr   (s1_addr),
        .s1_wdata  (s1_wdata),
        .s1_strb   (s1_strb),
        .s1_rdata  (s1_rdata),
        .s1_ready  (s1_ready),
        .s1_err    (s1_err),
        .slv_en    (slv_en),
        .slv_wr    (slv_wr),
        .slv_addr  (slv_addr),
        .slv_wdata (slv_wdata),
        .slv_strb  (slv_strb),
        .slv_rdata (slv_rdata),
        .slv_ready (slv_ready)
    );

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic rand_req(input int n);
        wr_q[n]    = 1'($urandom);
        addr_q[n]  = ADDRW'($urandom);
        wdata_q[n] = $urandom;
        strb_q[n]  = (XLEN/8)'($urandom);
        en_q[n]    = 1'b1;
    endtask

    task automatic chk_quiet(input string tag);
        chk({tag, "_s0_ready"}, s0_ready, 0);
        chk({tag, "_s1_ready"}, s1_ready, 0);
        chk({tag, "_s0_rdata"}, s0_rdata, 0);
        chk({tag, "_s1_rdata"}, s1_rdata, 0);
        chk({tag, "_s0_err"}, s0_err, 0);
        chk({tag, "_s1_err"}, s1_err, 0);
    endtask

    // Called at the falling edge of the first slv_en cycle of requester w.
    // Slave answers in the lat-th access cycle; beyond TO it times out.
    task automatic serve(input int w, input int lat, input logic [XLEN-1:0] rd);
        bit ok;
        int n;
        ok   = (lat >= 1) && (lat <= TO);
        n    = ok ? lat : TO;
        last = w[0];
        for (int j = 1; j <= n; j++) begin
            slv_ready = (j == lat);
            slv_rdata = (j == lat) ? rd : $urandom;
            chk("acc_slv_en", slv_en, 1);
            chk("acc_slv_wr", slv_wr, wr_q[w]);
            chk("acc_slv_addr", slv_addr, addr_q[w]);
            chk("acc_slv_wdata", slv_wdata, wdata_q[w]);
            chk("acc_slv_strb", slv_strb, strb_q[w]);
            chk_quiet("acc");
            @(negedge aclk);
        end
        // Slave noise outside ACCESS must be ignored
        slv_ready = 1'($urandom);
        slv_rdata = $urandom;
        chk("resp_slv_en", slv_en, 0);
        chk("resp_ready", w ? s1_ready : s0_ready, 1);
        chk("resp_rdata", w ? s1_rdata : s0_rdata, ok ? rd : 0);
        chk("resp_err", w ? s1_err : s0_err, ok ? 0 : 1);
        chk("resp_other_ready", w ? s0_ready : s1_ready, 0);
        chk("resp_other_rdata", w ? s0_rdata : s1_rdata, 0);
        chk("resp_other_err", w ? s0_err : s1_err, 0);
        en_q[w] = 1'b0;
        @(negedge aclk);
        chk("idle_slv_en", slv_en, 0);
        chk_quiet("idle");
    endtask

    task automatic round(input bit r0, input bit r1, input int lat0,
                         input int lat1);
        int first;
        if (r0) rand_req(0);
        if (r1) rand_req(1);
        @(negedge aclk);
        first = (r0 && r1) ? (last ? 0 : 1) : (r1 ? 1 : 0);
        serve(first, first ? lat1 : lat0, $urandom);
        if (r0 && r1) begin
            @(negedge aclk);
            serve(1 - first, first ? lat0 : lat1, $urandom);
        end
    endtask

    initial begin
        bit r0, r1;
        aresetn   = 1'b0;
        srst      = 1'b0;
        slv_ready = 1'b0;
        slv_rdata = '0;
        for (int i = 0; i < 2; i++) begin
            en_q[i]    = 1'b0;
            wr_q[i]    = 1'b0;
            addr_q[i]  = '0;
            wdata_q[i] = '0;
            strb_q[i]  = '0;
        end
        last = 1'b1;
        repeat (2) @(negedge aclk);
        chk("rst_slv_en", slv_en, 0);
        chk("rst_slv_addr", slv_addr, 0);
        chk("rst_slv_wdata", slv_wdata, 0);
        chk_quiet("rst");
        aresetn = 1'b1;
        @(negedge aclk);

        // s0 read, slave ready one cycle after slv_en
        wr_q[0] = 1'b0;  addr_q[0] = 16'h0010;
        wdata_q[0] = '0; strb_q[0] = '0;
        en_q[0] = 1'b1;
        @(negedge aclk);
        serve(0, 2, 32'hDEADBEEF);

        // Tie from reset: s0 then s1, then s0 again
        round(1, 1, 1, 2);
        round(1, 1, 3, 1);

        // s1 write
        wr_q[1] = 1'b1;  addr_q[1] = 16'h0004;
        wdata_q[1] = 32'h000000A5; strb_q[1] = 4'h1;
        en_q[1] = 1'b1;
        @(negedge aclk);
        serve(1, 1, $urandom);

        // Timeout, then ready exactly on the timeout cycle, then normal
        round(1, 0, 100, 0);
        round(1, 0, TO, 0);
        round(0, 1, 2, 0);
        round(1, 1, 100, 100);

        // Async reset in the middle of an access
        rand_req(0);
        @(negedge aclk);
        chk("arst_pre_slv_en", slv_en, 1);
        slv_ready = 1'b0;
        #2 aresetn = 1'b0;
        #1;
        chk("arst_slv_en", slv_en, 0);
        chk_quiet("arst");
        last = 1'b1;
        @(negedge aclk);
        chk_quiet("arst_hold");
        aresetn = 1'b1;
        @(negedge aclk);
        serve(0, 2, $urandom);

        // Sync reset in the middle of an access
        rand_req(1);
        @(negedge aclk);
        chk("srst_pre_slv_en", slv_en, 1);
        slv_ready = 1'b0;
        srst = 1'b1;
        @(negedge aclk);
        chk("srst_slv_en", slv_en, 0);
        chk_quiet("srst");
        srst = 1'b0;
        last = 1'b1;
        @(negedge aclk);
        serve(1, 1, $urandom);
        round(1, 1, 1, 1);

        for (int i = 0; i < 40; i++) begin
            r0 = 1'($urandom);
            r1 = 1'($urandom);
            if (!r0 && !r1) r0 = 1'b1;
            round(r0, r1, $urandom_range(1, TO + 2),
                  $urandom_range(1, TO + 2));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
        $finish;
    end

endmodule

// File: doc/friscv_apb_arbiter.md
FRISCV_APB_ARBITER -- requirements
Module: friscv_apb_arbiter

Interface
REQ-001 SHALL have parameter ADDRW, default 16: address width of every port.
REQ-002 SHALL have parameter XLEN, default 32: data width; strobe width XLEN/8.
REQ-003 SHALL have parameter TIMEOUT, default 255: max cycles waiting for slv_ready; 0 disables the timeout.
REQ-004 SHALL have port aclk  in  1  clock; all logic on rising edge.
REQ-005 SHALL have port aresetn  in  1  reset, asynchronous, active-low.
REQ-006 SHALL have port srst  in  1  synchronous reset, active-high.
REQ-007 SHALL have, for N in {0,1}, ports sN_en in 1, sN_wr in 1, sN_addr in ADDRW, sN_wdata in XLEN, sN_strb in XLEN/8: requester N access request.
REQ-008 SHALL have, for N in {0,1}, ports sN_rdata out XLEN, sN_ready out 1, sN_err out 1: requester N completion.
REQ-009 SHALL have ports slv_en out 1, slv_wr out 1, slv_addr out ADDRW, slv_wdata out XLEN, slv_strb out XLEN/8: shared peripheral request.
REQ-010 SHALL have ports slv_rdata in XLEN, slv_ready in 1: shared peripheral completion.

Function
REQ-011 SHALL implement FSM IDLE -> ACCESS -> RESP -> IDLE, one grant at a time.
REQ-012 IDLE: if any sN_en=1, SHALL latch the winner's wr/addr/wdata/strb and index, then go to ACCESS next cycle; otherwise stay.
REQ-013 Arbitration SHALL be round-robin: single requester wins; on a tie, the requester not granted last wins; last-grant pointer updates on each grant.
REQ-014 ACCESS: slv_en SHALL be 1 and slv_* SHALL carry the latched payload, stable for the whole state.
REQ-015 ACCESS with slv_ready=1: next cycle SHALL drive slv_en=0, pulse winner sN_ready=1 for exactly one cycle with sN_rdata=slv_rdata (captured, valid for reads and writes), sN_err=0, and enter RESP.
REQ-016 RESP SHALL last exactly one cycle, then IDLE; this turnaround lets the requester drop sN_en before re-arbitration.
REQ-017 Latency SHALL be: request sampled at cycle 0, slv_en=1 from cycle 1, slave ready at cycle k>=1, sN_ready=1 at cycle k+1.
REQ-018 Timeout counter SHALL clear on entry to ACCESS and increment each ACCESS cycle without slv_ready; on reaching TIMEOUT (if nonzero) SHALL act as REQ-015 but with sN_rdata=0 and sN_err=1.
REQ-019 slv_ready coinciding with the timeout cycle SHALL count as normal completion (err=0).
REQ-020 slv_ready outside ACCESS SHALL be ignored.
REQ-021 The losing requester's outputs SHALL stay 0; its request stays pending and SHALL win the next IDLE arbitration.
REQ-022 sN_rdata SHALL be 0 in every cycle where sN_ready=0.
REQ-023 Counter width SHALL be $clog2(TIMEOUT+1), minimum 1 bit; no wrap occurs since it stops at TIMEOUT.

Reset
REQ-024 On aresetn=0 (asynchronous) or srst=1 (synchronous), state SHALL be IDLE, all outputs 0, counter 0, last-grant pointer = 1 (requester 0 wins the first tie).
REQ-025 Reset mid-ACCESS SHALL abort: slv_en=0 after reset, no sN_ready pulse issued for the aborted access.

Structure
REQ-026 FSM state typedef and encoding SHALL live in the shared package header friscv_h.sv.
REQ-027 Implementation SHALL be a single module with no sub-modules; TIMEOUT=0 SHALL remove the counter logic.

Verification
REQ-028 s0 read addr 0x0010, slave ready one cycle after slv_en, slv_rdata=0xDEADBEEF -> s0_ready pulse at cycle 3, s0_rdata=0xDEADBEEF, s0_err=0.
REQ-029 s0 and s1 both request from reset -> s0 served first, then s1; repeat tie -> s0 again (alternation), never two slv_en grants overlapping.
REQ-030 s1 write addr 0x0004, wdata 0x000000A5, strb 0x1 -> slv_* match exactly while slv_en=1, s1_ready one pulse.
REQ-031 TIMEOUT=4, slave never ready -> slv_en high 4 cycles, then s0_ready=1, s0_err=1, s0_rdata=0; next request served normally.
REQ-032 aresetn low during ACCESS -> slv_en=0 immediately, no ready pulse; after release first access completes normally.
